// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// instruction geometry, field positions and addressing-mode encodings.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDone
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 3;
    localparam int unsigned CNT_W       = $clog2(INSTR_BYTES);
    localparam int unsigned INSTR_W     = 24;

    localparam int unsigned OPCODE_MSB = 23;
    localparam int unsigned OPCODE_LSB = 20;
    localparam int unsigned MODE_A_MSB = 17;
    localparam int unsigned MODE_A_LSB = 16;
    localparam int unsigned REG_A_MSB  = 13;
    localparam int unsigned REG_A_LSB  = 10;
    localparam int unsigned MODE_B_MSB = 9;
    localparam int unsigned MODE_B_LSB = 8;

    typedef enum logic [1:0] {
        ModeRegDirect = 2'b00,
        ModeMemDirect = 2'b01,
        ModeIndexed   = 2'b10,
        ModeImmediate = 2'b11
    } addr_mode_e;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_byte_shift.sv
// Byte capture register: stores one ROM byte per load at the given index and
// presents the bytes as one word with byte 0 in the most significant position.
module instr_byte_shift
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [CNT_W-1:0]              idx,
    input  logic [DATA_W-1:0]             din,
    output logic [INSTR_BYTES*DATA_W-1:0] word
);

    logic [INSTR_BYTES-1:0][DATA_W-1:0] bytes_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bytes_q <= '0;
        end else begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (load && (idx == CNT_W'(i))) begin
                    bytes_q[i] <= din;
                end
            end
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < INSTR_BYTES; i++) begin
            word[(INSTR_BYTES-1-i)*DATA_W +: DATA_W] = bytes_q[i];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks the program ROM from address 0, assembles
// 3-byte instructions and hands them to the decoder over valid/ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 6,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] PROG_LAST = 6'd32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_cs,
    input  logic [DATA_W-1:0]             rom_data,
    output logic [INSTR_BYTES*DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]             instr_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic                          busy,
    output logic                          done
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W:0]   next_last;
    logic              has_next;

    // Extra bit keeps the bound check from wrapping near the top of the ROM.
    assign next_last = {1'b0, pc} + (ADDR_W+1)'(INSTR_BYTES - 1);
    assign has_next  = (next_last <= {1'b0, PROG_LAST});

    instr_byte_shift #(
        .DATA_W (DATA_W)
    ) u_byte_shift (
        .clk  (clk),
        .rst  (rst),
        .load (state == StFetch),
        .idx  (cnt),
        .din  (rom_data),
        .word (instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            pc          <= '0;
            cnt         <= '0;
            rom_addr    <= '0;
            rom_cs      <= 1'b0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StFetch;
                        pc       <= '0;
                        cnt      <= '0;
                        rom_addr <= '0;
                        rom_cs   <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                StFetch: begin
                    rom_addr <= rom_addr + 1'b1;
                    pc       <= pc + 1'b1;
                    if (cnt == CNT_W'(INSTR_BYTES - 1)) begin
                        state       <= StHold;
                        rom_cs      <= 1'b0;
                        instr_valid <= 1'b1;
                        // pc still points at the last byte fetched.
                        instr_pc    <= pc - ADDR_W'(INSTR_BYTES - 1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (has_next) begin
                            state  <= StFetch;
                            rom_cs <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
